// File: rtl/hs_dpath_sfr_ctrl_pkg.sv
// Shared types and helpers for the CE-pipeline flow controller.
// Holds the controller state encoding and the occupancy width rule.
package hs_dpath_sfr_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } sfr_ctrl_state_e;

    // Occupancy must represent 0..latency inclusive.
    function automatic int occ_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/hs_dpath_sfr_ctrl_if.sv
// Handshake, control and status bundle between the flow controller and its surroundings.
// "slave" is the controller side; "master" is the producer/consumer/supervisor side.
interface hs_dpath_sfr_ctrl_if
    import hs_dpath_sfr_ctrl_pkg::*;
#(
    parameter int LATENCY = 1
) ();
    localparam int OCC_W = occ_width(LATENCY);

    logic             s_valid;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic             ce;
    logic             flush;
    logic             drain_req;
    logic             drain_done;
    logic [OCC_W-1:0] occ;
    logic             busy;

    modport slave (
        input  s_valid, m_ready, flush, drain_req,
        output s_ready, m_valid, ce, drain_done, occ, busy
    );

    modport master (
        output s_valid, m_ready, flush, drain_req,
        input  s_ready, m_valid, ce, drain_done, occ, busy
    );

endinterface

// File: rtl/hs_dpath_occ_cnt.sv
// Up/down occupancy counter with synchronous clear and a "next value is zero" flag.
// Increment at MAX and decrement at zero are ignored so the count can never wrap.
module hs_dpath_occ_cnt #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         zero_next
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign zero_next = (cnt_d == '0);

endmodule

// File: rtl/hs_dpath_sfr_ctrl.sv
// Valid/ready sequencer for an external LATENCY-deep clock-enabled shift datapath.
// state | meaning
// RUN   | normal streaming, intake open unless drain_req
// DRAIN | intake closed, pipe advancing until empty
// HALT  | pipe empty and intake closed, drain_done high
module hs_dpath_sfr_ctrl
    import hs_dpath_sfr_ctrl_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    hs_dpath_sfr_ctrl_if.slave   bus
);
    localparam int OCC_W = occ_width(LATENCY);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    sfr_ctrl_state_e    state_q;
    sfr_ctrl_state_e    state_d;

    logic             ce_c;
    logic             s_ready_c;
    logic             acc_c;
    logic             emit_c;
    logic [OCC_W-1:0] occ_c;
    logic             occ_zero_next;

    // Global stall: every stage freezes together when the tail is blocked.
    assign ce_c      = aresetn & ~bus.flush & (~vld_q[LATENCY-1] | bus.m_ready);
    assign s_ready_c = ce_c & (state_q == RUN) & ~bus.drain_req;
    assign acc_c     = s_ready_c & bus.s_valid;
    assign emit_c    = ce_c & vld_q[LATENCY-1];

    always_comb begin
        vld_d = vld_q;
        if (bus.flush) begin
            vld_d = '0;
        end else if (ce_c) begin
            vld_d[0] = acc_c;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.drain_req && !bus.flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.flush || (occ_c == '0) || occ_zero_next) state_d = HALT;
            end
            HALT: begin
                if (!bus.drain_req && !bus.flush) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            vld_q   <= '0;
            state_q <= RUN;
        end else begin
            vld_q   <= vld_d;
            state_q <= state_d;
        end
    end

    hs_dpath_occ_cnt #(
        .MAX (LATENCY),
        .W   (OCC_W)
    ) u_occ_cnt (
        .clk       (clk),
        .aresetn   (aresetn),
        .inc       (acc_c),
        .dec       (emit_c),
        .clr       (bus.flush),
        .cnt       (occ_c),
        .zero_next (occ_zero_next)
    );

    assign bus.ce         = ce_c;
    assign bus.s_ready    = s_ready_c;
    assign bus.m_valid    = aresetn & vld_q[LATENCY-1] & ~bus.flush;
    assign bus.drain_done = aresetn & (state_q == HALT);
    assign bus.occ        = occ_c;
    assign bus.busy       = (occ_c != '0);

endmodule

// File: tb/tb_hs_dpath_sfr_ctrl.sv
// Bench for hs_dpath_sfr_ctrl: LATENCY=3 and LATENCY=1 controllers share one stimulus stream,
// each wrapping a bench-side CE shift datapath; a beat-age model and a payload scoreboard judge them.
module tb_hs_dpath_sfr_ctrl;

    localparam int LAT [2] = '{3, 1};

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        flush = 1'b0;
    logic        drain_req = 1'b0;
    logic [15:0] s_data = 16'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hs_dpath_sfr_ctrl_if #(.LATENCY(3)) bus3 ();
    hs_dpath_sfr_ctrl_if #(.LATENCY(1)) bus1 ();

    hs_dpath_sfr_ctrl #(.LATENCY(3)) u_dut3 (.clk(clk), .aresetn(aresetn), .bus(bus3));
    hs_dpath_sfr_ctrl #(.LATENCY(1)) u_dut1 (.clk(clk), .aresetn(aresetn), .bus(bus1));

    assign bus3.s_valid   = s_valid;
    assign bus3.m_ready   = m_ready;
    assign bus3.flush     = flush;
    assign bus3.drain_req = drain_req;
    assign bus1.s_valid   = s_valid;
    assign bus1.m_ready   = m_ready;
    assign bus1.flush     = flush;
    assign bus1.drain_req = drain_req;

    // Payload datapath the controllers sequence; it has no reset of its own.
    logic [15:0] dp3 [3];
    logic [15:0] dp1;
    always @(posedge clk) begin
        if (bus3.ce) begin
            dp3[0] <= s_data;
            dp3[1] <= dp3[0];
            dp3[2] <= dp3[1];
        end
        if (bus1.ce) dp1 <= s_data;
    end

    logic [15:0] dout_w [2];
    logic        ce_w [2];
    logic        sr_w [2];
    logic        mv_w [2];
    logic        dd_w [2];
    logic        busy_w [2];
    int          occ_w [2];

    assign dout_w[0] = dp3[2];
    assign dout_w[1] = dp1;
    assign ce_w[0]   = bus3.ce;
    assign ce_w[1]   = bus1.ce;
    assign sr_w[0]   = bus3.s_ready;
    assign sr_w[1]   = bus1.s_ready;
    assign mv_w[0]   = bus3.m_valid;
    assign mv_w[1]   = bus1.m_valid;
    assign dd_w[0]   = bus3.drain_done;
    assign dd_w[1]   = bus1.drain_done;
    assign busy_w[0] = bus3.busy;
    assign busy_w[1] = bus1.busy;
    assign occ_w[0]  = int'(bus3.occ);
    assign occ_w[1]  = int'(bus1.occ);

    task automatic chk(input int k, input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s lat=%0d t=%0t got=%0d want=%0d", nm, LAT[k], $time, act, exp);
        end
    endtask

    // Model: every in-flight beat remembers the global advance count at entry;
    // its stage index is simply how many advances it has seen since.
    int          stamp_q [2][$];
    logic [15:0] sb_q [2][$];
    int          adv [2] = '{0, 0};
    int          st [2]  = '{0, 0};   // 0 run, 1 drain, 2 halt

    bit head_end, e_ce, e_mv, e_sr, e_acc;
    int sz_old, sz_new;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            sz_old   = stamp_q[k].size();
            head_end = (sz_old > 0) && ((adv[k] - stamp_q[k][0]) == LAT[k] - 1);
            e_ce     = aresetn && !flush && (!head_end || m_ready);
            e_mv     = aresetn && !flush && head_end;
            e_sr     = e_ce && (st[k] == 0) && !drain_req;
            e_acc    = e_sr && s_valid;

            chk(k, "ce", int'(ce_w[k]), int'(e_ce));
            chk(k, "m_valid", int'(mv_w[k]), int'(e_mv));
            chk(k, "s_ready", int'(sr_w[k]), int'(e_sr));
            chk(k, "drain_done", int'(dd_w[k]), int'(aresetn && st[k] == 2));
            chk(k, "occ", occ_w[k], sz_old);
            chk(k, "busy", int'(busy_w[k]), int'(sz_old != 0));
            chk(k, "occ_range", int'(occ_w[k] <= LAT[k]), 1);

            if (!aresetn) begin
                stamp_q[k].delete();
                sb_q[k].delete();
                st[k] = 0;
            end else begin
                if (flush) begin
                    stamp_q[k].delete();
                    sb_q[k].delete();
                end else if (e_ce) begin
                    adv[k]++;
                    if (head_end) void'(stamp_q[k].pop_front());
                    if (e_acc) begin
                        stamp_q[k].push_back(adv[k]);
                        sb_q[k].push_back(s_data);
                    end
                end
                sz_new = stamp_q[k].size();
                case (st[k])
                    0: if (drain_req && !flush) st[k] = 1;
                    1: if (flush || sz_old == 0 || sz_new == 0) st[k] = 2;
                    default: if (!drain_req && !flush) st[k] = 0;
                endcase
            end
        end
    end

    // Monitor: consumes a scoreboard entry whenever a DUT completes a downstream transfer.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (aresetn && mv_w[k] && m_ready) begin
                if (sb_q[k].size() == 0) begin
                    chk(k, "sb_underrun", 1, 0);
                end else begin
                    chk(k, "payload", int'(dout_w[k]), int'(sb_q[k].pop_front()));
                end
            end
        end
    end

    task automatic cyc(input bit sv, input bit mr, input bit fl, input bit dr, input bit rn);
        @(posedge clk);
        #1;
        s_valid   = sv;
        m_ready   = mr;
        flush     = fl;
        drain_req = dr;
        aresetn   = rn;
        s_data    = 16'($urandom);
    endtask

    initial begin
        bit dr;
        repeat (3) cyc(0, 0, 0, 0, 0);
        // streaming at full rate
        repeat (4) cyc(1, 1, 0, 0, 1);
        repeat (5) cyc(0, 1, 0, 0, 1);
        // fill, hold under back-pressure, then release
        repeat (6) cyc(1, 0, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);
        repeat (5) cyc(0, 1, 0, 0, 1);
        // flush colliding with upstream and downstream activity
        repeat (2) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 1);
        repeat (3) cyc(0, 1, 0, 0, 1);
        // drain with intake pressure, then reopen
        repeat (4) cyc(1, 0, 0, 0, 1);
        repeat (8) cyc(1, 1, 0, 1, 1);
        repeat (3) cyc(1, 1, 0, 0, 1);
        // mid-stream reset
        repeat (3) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 1);
        // randomized traffic
        dr = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 39) == 0) dr = !dr;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                $urandom_range(0, 49) == 0, dr, $urandom_range(0, 299) != 0);
        end
        repeat (6) cyc(0, 1, 0, 0, 1);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_dpath_sfr_ctrl.md
Name: hs_dpath_sfr_ctrl

Overview:
Valid/ready flow controller that sequences an external LATENCY-deep clock-enabled shift-register datapath (hs_dpath_sfr_ce instances for the payload).
- Tracks per-stage valid bits and generates the shared stage clock enable `ce` from downstream back-pressure.
- Exposes an AXI-Stream-like valid/ready handshake on the upstream and downstream sides.
- Provides occupancy, a drain sequence and a single-cycle flush.
- Sits between a producer and consumer wrapping any fixed-latency CE pipeline.

Parameters:
LATENCY, 1, pipeline depth in stages; must match the controlled datapath; range 1..1024
OCC_W, $clog2(LATENCY+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock
aresetn  input  1  reset, synchronous, active-low
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream ready; beat accepted when s_valid & s_ready
m_valid  output  1  downstream beat valid (payload = datapath dout)
m_ready  input  1  downstream ready
ce  output  1  clock enable to every datapath stage
flush  input  1  single-cycle pulse; discards all in-flight beats
drain_req  input  1  level; stop intake and empty the pipe
drain_done  output  1  level; pipe empty and intake halted under drain_req
occ  output  OCC_W  number of valid beats in flight
busy  output  1  occ != 0

Behaviour:
- Reset is sampled only on the rising edge of clk. While aresetn=0, all of these hold: vld[]=0, occ=0, state=RUN, s_ready=0, ce=0, m_valid=0, drain_done=0.
- Valid tracking: internal vld[0..LATENCY-1].
  - Each ce edge: vld[0] <= s_valid & s_ready; vld[i] <= vld[i-1].
  - No ce: vld holds.
- ce = !flush & (!vld[LATENCY-1] | m_ready). This is a global stall with no bubble collapse, and it is combinational from m_ready.
- m_valid = vld[LATENCY-1] & !flush.
- s_ready = ce & (state==RUN) & !drain_req.
- Latency: a beat accepted at edge t, with ce high throughout, gives m_valid=1 in cycle t+LATENCY-1 (registered, LATENCY stages). Each stalled cycle adds one.
- occ register:
  - occ_next = occ + (ce & s_valid & s_ready) - (ce & vld[LATENCY-1]).
  - Range 0..LATENCY. Overflow and underflow are impossible by construction; the bench asserts this.
- busy = (occ != 0).
- FSM (states in package):
  - RUN: drain_req=1 moves to DRAIN.
  - DRAIN: intake blocked; the pipe advances normally. When occ==0, or occ_next==0, move to HALT.
  - HALT: drain_done=1; s_ready=0. drain_req=0 returns to RUN next cycle.
- Flush, in any state:
  - In the flush cycle: s_ready=0, ce=0, m_valid=0.
  - At the next edge: vld[]=0 and occ=0.
  - State: DRAIN→HALT; RUN stays RUN; HALT stays HALT.
  - flush+s_valid in the same cycle: the beat is not accepted.
  - flush+m_ready in the same cycle: no transfer.
- Simultaneous drain_req assertion and s_valid: s_ready is already 0, so no accept.
- LATENCY=1: vld is a single bit; all rules above apply unchanged.
- The payload datapath's own reset is not driven here. Stale payload is harmless because validity comes only from vld.

Decomposition:
- Package hs_dpath_sfr_ctrl_pkg:
  - enum sfr_ctrl_state_e {RUN, DRAIN, HALT} (2-bit);
  - function occ_width(latency) returning $clog2(latency+1).
- One natural sub-module: hs_dpath_occ_cnt, an up/down saturating-checked counter with sync active-low reset, inc/dec inputs, and a zero-next flag. It is reusable by other flow controllers.
- The vld shifter stays inline; hs_dpath_sfr_ce is not reused for it because its reset style differs.

Test Plan:
1. LATENCY=3, reset then s_valid=1 for 4 cycles with m_ready=1. First m_valid is 3 cycles after the first accept; 4 consecutive m_valid; occ peaks at 3; ce=1 throughout.
2. LATENCY=3, pipe full (occ=3), m_ready=0 for 5 cycles. ce=0, s_ready=0, m_valid=1 steady, occ=3. On m_ready=1, one beat per cycle drains in order.
3. LATENCY=4, occ=2, assert flush together with s_valid=1 and m_ready=1. No accept and no transfer that cycle; next cycle occ=0, m_valid=0, busy=0.
4. LATENCY=3, occ=3, drain_req=1 with s_valid=1 held. s_ready=0 immediately. After 3 beats emitted, state HALT, drain_done=1. drain_req=0 gives s_ready=1 the next cycle.
5. LATENCY=2, mid-stream (occ=2) drive aresetn=0 for 1 cycle. At the next edge occ=0, m_valid=0, state RUN, no spurious output afterwards.
6. LATENCY=1, random s_valid/m_ready for 1000 cycles against a scoreboard. Beat order is preserved; occ∈{0,1}; occ equals accepts minus emits at every cycle.
